// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter: round-robin sharing of one APB master port among NUM_REQ
// local requesters. Each requester posts one command on req_i and waits for
// its done_o pulse. The arbiter runs SETUP/ACCESS on the shared bus and
// returns read data and error status.
// Optional feature: define APB_ARB_TIMEOUT_EN to add an ACCESS-phase watchdog
// that aborts a transfer with err_o=1 after TIMEOUT cycles without pready.
module apb_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        wr_i,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        done_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      err_o,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  input  logic [DATA_W-1:0]         prdata,
  input  logic                      pready,
  input  logic                      pslverr
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Reject unsupported configurations at elaboration time.
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 2) begin : g_bad_param
    $error("apb_rr_arbiter: NUM_REQ must be 2..8 and TIMEOUT >= 2");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] rr_ptr;    // first index to search at the next grant
  logic [PTR_W-1:0] win_idx;
  logic             win_found;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT);
  logic [CNT_W-1:0] to_cnt;    // ACCESS cycles already spent without pready
`endif

  // Round-robin search: the first requester at or after rr_ptr, wrapping.
  always_comb begin : pick_winner
    int idx;
    // NOTE: every variable gets a default before the loop so no path leaves
    // it unassigned, which would otherwise infer a latch.
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    // Walk offsets from farthest to nearest so the nearest match is kept.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (req_i[idx]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(idx);
      end
    end
  end

  // Arbitration FSM with all bus and requester outputs registered.
  always_ff @(posedge pclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (preset) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      gnt_o   <= '0;
      done_o  <= '0;
      rdata_o <= '0;
      err_o   <= 1'b0;
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      to_cnt  <= '0;
`endif
    end else begin
      done_o <= '0;
      case (state)
        IDLE: begin
          if (win_found) begin
            gnt_o          <= '0;
            gnt_o[win_idx] <= 1'b1;
            pwrite         <= wr_i[win_idx];
            paddr          <= addr_i[win_idx*ADDR_W +: ADDR_W];
            pwdata         <= wdata_i[win_idx*DATA_W +: DATA_W];
            psel           <= 1'b1;
            penable        <= 1'b0;
            rr_ptr         <= PTR_W'((int'(win_idx) + 1) % NUM_REQ);
            state          <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
          to_cnt  <= '0;
`endif
          state   <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            done_o  <= gnt_o;
            if (!pwrite) rdata_o <= prdata;
            err_o   <= pslverr;
            gnt_o   <= '0;
            psel    <= 1'b0;
            penable <= 1'b0;
            state   <= IDLE;
          end
`ifdef APB_ARB_TIMEOUT_EN
          else if (to_cnt == CNT_W'(TIMEOUT - 1)) begin
            // Watchdog abort: report an error but keep the old read data.
            done_o  <= gnt_o;
            err_o   <= 1'b1;
            gnt_o   <= '0;
            psel    <= 1'b0;
            penable <= 1'b0;
            state   <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        default: begin
          gnt_o   <= '0;
          psel    <= 1'b0;
          penable <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
